pwl_sigmoid_pipe: RTL

//  Pipelined, parametrised piecewise-linear sigmoid: y = m[k]*x + c[k], segment k picked by runtime-loadable breakpoints.

---
 rtl/pwl_sigmoid_pkg.sv | 118 +++++++++++
 rtl/pwl_seg_select.sv | 23 ++
 rtl/pwl_sigmoid_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pwl_sigmoid_pkg.sv
// Shared sign-magnitude arithmetic and default 9-segment Q4.27 sigmoid table
// for the piecewise-linear activation blocks.
package pwl_sigmoid_pkg;

    localparam int SM_MAX_W = 64;
    typedef logic [SM_MAX_W-1:0] sm_word_t;

    typedef enum logic [1:0] {
        CFG_BP   = 2'd0,
        CFG_M    = 2'd1,
        CFG_C    = 2'd2,
        CFG_NONE = 2'd3
    } cfg_sel_e;

    localparam int DEF_N_SEG = 9;

    localparam logic [31:0] DEF_BP [0:7] = '{
        32'hA800_0000, 32'h9C00_0000, 32'h9200_0000, 32'h8859_817D,
        32'h0859_817D, 32'h1200_0000, 32'h1C00_0000, 32'h2800_0000
    };

    localparam logic [31:0] DEF_M [0:8] = '{
        32'h0000_0000, 32'h0020_0000, 32'h0080_0000, 32'h0100_0000,
        32'h0200_0000, 32'h0100_0000, 32'h0080_0000, 32'h0020_0000,
        32'h0000_0000
    };

    localparam logic [31:0] DEF_C [0:8] = '{
        32'h0000_AFD8, 32'h00C0_0000, 32'h0200_0000, 32'h0300_0000,
        32'h03FF_FFF0, 32'h0500_0000, 32'h0600_0000, 32'h0740_0000,
        32'h07FF_5027
    };

    function automatic sm_word_t sm_mag_max(int unsigned w);
        return (sm_word_t'(1) << (w - 1)) - sm_word_t'(1);
    endfunction

    function automatic logic sm_sign(sm_word_t a, int unsigned w);
        return ((a >> (w - 1)) & sm_word_t'(1)) != '0;
    endfunction

    // A zero magnitude is always packed as +0.
    function automatic sm_word_t sm_pack(logic s, sm_word_t mag, int unsigned w);
        return (!s || mag == '0) ? mag : (mag | (sm_word_t'(1) << (w - 1)));
    endfunction

    function automatic sm_word_t sm_mul(sm_word_t a, sm_word_t b,
                                        int unsigned w, int unsigned f);
        sm_word_t                mmax;
        sm_word_t                mag;
        logic [2*SM_MAX_W-1:0]   prod;
        mmax = sm_mag_max(w);
        prod = ({{SM_MAX_W{1'b0}}, a & mmax} * {{SM_MAX_W{1'b0}}, b & mmax}) >> f;
        mag  = (prod > {{SM_MAX_W{1'b0}}, mmax}) ? mmax : prod[SM_MAX_W-1:0];
        return sm_pack(sm_sign(a, w) ^ sm_sign(b, w), mag, w);
    endfunction

    function automatic sm_word_t sm_add(sm_word_t a, sm_word_t b, int unsigned w);
        sm_word_t          mmax;
        sm_word_t          am;
        sm_word_t          bm;
        sm_word_t          mag;
        logic              s;
        logic [SM_MAX_W:0] sum;
        mmax = sm_mag_max(w);
        am   = a & mmax;
        bm   = b & mmax;
        sum  = {1'b0, am} + {1'b0, bm};
        if (sm_sign(a, w) == sm_sign(b, w)) begin
            s   = sm_sign(a, w);
            mag = (sum > {1'b0, mmax}) ? mmax : sum[SM_MAX_W-1:0];
        end else if (am >= bm) begin
            s   = sm_sign(a, w);
            mag = am - bm;
        end else begin
            s   = sm_sign(b, w);
            mag = bm - am;
        end
        return sm_pack(s, mag, w);
    endfunction

    // Signed compare a >= b where -0 equals +0.
    function automatic logic sm_ge(sm_word_t a, sm_word_t b, int unsigned w);
        sm_word_t am;
        sm_word_t bm;
        logic     an;
        logic     bn;
        logic     r;
        am = a & sm_mag_max(w);
        bm = b & sm_mag_max(w);
        an = sm_sign(a, w) && (am != '0);
        bn = sm_sign(b, w) && (bm != '0);
        if (an && bn)
            r = (am <= bm);
        else if (an)
            r = 1'b0;
        else if (bn)
            r = 1'b1;
        else
            r = (am >= bm);
        return r;
    endfunction

    function automatic logic [31:0] default_entry(cfg_sel_e sel, int idx, int n_seg);
        logic [31:0] v;
        v = '0;
        if (n_seg == DEF_N_SEG && idx >= 0 && idx < DEF_N_SEG) begin
            unique case (1'b1)
                sel == CFG_BP: if (idx < DEF_N_SEG - 1) v = DEF_BP[idx[2:0]];
                sel == CFG_M:  v = DEF_M[idx[3:0]];
                sel == CFG_C:  v = DEF_C[idx[3:0]];
                default:       v = '0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// Segment index for the PWL activation: number of breakpoints the
// sample is greater than or equal to.
module pwl_seg_select
    import pwl_sigmoid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_SEG  = 9,
    parameter int SEG_W  = $clog2(N_SEG)
) (
    input  logic [DATA_W-1:0]            x,
    input  logic [N_SEG-2:0][DATA_W-1:0] bp,
    output logic [SEG_W-1:0]             seg
);

    always_comb begin
        seg = '0;
        for (int i = 0; i < N_SEG - 1; i++) begin
            if (sm_ge(sm_word_t'(x), sm_word_t'(bp[i]), DATA_W))
                seg = seg + SEG_W'(1);
        end
    end

endmodule

// File: rtl/pwl_sigmoid_pipe.sv
// 3-stage streaming piecewise-linear sigmoid with a writable table.
// Define PWL_SAT_EN to clamp the result to [+0, 1.0].
module pwl_sigmoid_pipe
    import pwl_sigmoid_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 27,
    parameter int N_SEG  = 9,
    parameter int SEG_W  = $clog2(N_SEG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [SEG_W-1:0]  cfg_idx,
    input  logic [DATA_W-1:0] cfg_data
);

    logic [N_SEG-2:0][DATA_W-1:0] bp_q;
    logic [N_SEG-1:0][DATA_W-1:0] m_q;
    logic [N_SEG-1:0][DATA_W-1:0] c_q;

    logic [SEG_W-1:0]  seg;
    cfg_sel_e          sel;
    logic              advance;
    logic              s1_valid;
    logic              s2_valid;
    logic              s3_valid;
    logic [DATA_W-1:0] s1_x;
    logic [DATA_W-1:0] s1_m;
    logic [DATA_W-1:0] s1_c;
    logic [DATA_W-1:0] s2_p;
    logic [DATA_W-1:0] s2_c;
    logic [DATA_W-1:0] s3_y;
    logic [DATA_W-1:0] mul_res;
    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] y_next;

    // Whole pipe stalls only when the output register is full and blocked.
    assign advance   = !s3_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid;
    assign out_data  = s3_y;
    assign sel       = cfg_sel_e'(cfg_sel);

    pwl_seg_select #(
        .DATA_W (DATA_W),
        .N_SEG  (N_SEG),
        .SEG_W  (SEG_W)
    ) u_seg (
        .x   (in_data),
        .bp  (bp_q),
        .seg (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SEG - 1; i++)
                bp_q[i] <= DATA_W'(default_entry(CFG_BP, i, N_SEG));
            for (int i = 0; i < N_SEG; i++) begin
                m_q[i] <= DATA_W'(default_entry(CFG_M, i, N_SEG));
                c_q[i] <= DATA_W'(default_entry(CFG_C, i, N_SEG));
            end
        end else if (cfg_we) begin
            unique case (1'b1)
                sel == CFG_BP:
                    for (int i = 0; i < N_SEG - 1; i++)
                        if (cfg_idx == SEG_W'(i)) bp_q[i] <= cfg_data;
                sel == CFG_M:
                    for (int i = 0; i < N_SEG; i++)
                        if (cfg_idx == SEG_W'(i)) m_q[i] <= cfg_data;
                sel == CFG_C:
                    for (int i = 0; i < N_SEG; i++)
                        if (cfg_idx == SEG_W'(i)) c_q[i] <= cfg_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        mul_res = DATA_W'(sm_mul(sm_word_t'(s1_x), sm_word_t'(s1_m), DATA_W, FRAC_W));
        add_res = DATA_W'(sm_add(sm_word_t'(s2_p), sm_word_t'(s2_c), DATA_W));
        y_next  = add_res;
`ifdef PWL_SAT_EN
        if (add_res[DATA_W-1])
            y_next = '0;
        else if (add_res > (DATA_W'(1) << FRAC_W))
            y_next = DATA_W'(1) << FRAC_W;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_x     <= '0;
            s1_m     <= '0;
            s1_c     <= '0;
            s2_p     <= '0;
            s2_c     <= '0;
            s3_y     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_x     <= in_data;
            s1_m     <= m_q[seg];
            s1_c     <= c_q[seg];
            s2_valid <= s1_valid;
            s2_p     <= mul_res;
            s2_c     <= s1_c;
            s3_valid <= s2_valid;
            s3_y     <= y_next;
        end
    end

endmodule
